// File: rtl/setpoint_editor.sv
`timescale 1ns/1ps
// Setpoint editor: debounced 5-button UI that edits an 8-digit decimal setpoint
// digit by digit, with saturating arithmetic, idle timeout and a one-cycle commit pulse.
module setpoint_editor #(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned TIMEOUT_CYCLES  = 500_000_000,
  parameter logic [31:0] MAX_VALUE       = 32'd99_999_999,
  parameter logic [31:0] INIT_SETPOINT   = 32'd25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_center,
  input  logic [31:0] live_value,
  output logic [31:0] n,
  output logic [2:0]  blink,
  output logic        blink_ena,
  output logic [31:0] setpoint,
  output logic        commit,
  output logic        editing
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam int unsigned B_RIGHT  = 0;
  localparam int unsigned B_LEFT   = 1;
  localparam int unsigned B_DOWN   = 2;
  localparam int unsigned B_UP     = 3;
  localparam int unsigned B_CENTER = 4;

  if (CLK_HZ == 0 || DEBOUNCE_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("setpoint_editor: CLK_HZ, DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be non-zero");
  end

  typedef enum logic {S_VIEW, S_EDIT} state_e;

  logic [4:0]    btn_raw;
  logic [4:0]    sync1_q, sync2_q;
  logic [4:0]    deb_q, deb_d;
  logic [DW-1:0] cnt_q [5];
  logic [DW-1:0] cnt_d [5];
  logic [4:0]    press_q;

  state_e        state_q, state_d;
  logic [31:0]   working_q, working_d;
  logic [2:0]    cursor_q, cursor_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   setpoint_q, setpoint_d;
  logic          commit_q, commit_d;
  logic [31:0]   n_q, n_d;
  logic [31:0]   step;
  logic [32:0]   up_sum;

  assign btn_raw = {btn_center, btn_up, btn_down, btn_left, btn_right};

  function automatic logic [31:0] step_of(input logic [2:0] c);
    case (c)
      3'd0:    return 32'd1;
      3'd1:    return 32'd10;
      3'd2:    return 32'd100;
      3'd3:    return 32'd1_000;
      3'd4:    return 32'd10_000;
      3'd5:    return 32'd100_000;
      3'd6:    return 32'd1_000_000;
      default: return 32'd10_000_000;
    endcase
  endfunction

  // Debounced level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < 5; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      press_q <= '0;
      for (int unsigned i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= deb_d & ~deb_q;
      for (int unsigned i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign step   = step_of(cursor_q);
  assign up_sum = {1'b0, working_q} + {1'b0, step};

  always_comb begin
    state_d    = state_q;
    working_d  = working_q;
    cursor_d   = cursor_q;
    timer_d    = timer_q;
    setpoint_d = setpoint_q;
    commit_d   = 1'b0;
    case (state_q)
      S_VIEW: begin
        if (press_q[B_CENTER]) begin
          state_d   = S_EDIT;
          working_d = setpoint_q;
          cursor_d  = '0;
          timer_d   = '0;
        end
      end
      S_EDIT: begin
        timer_d = timer_q + 1'b1;
        // The if-chain order is the event priority; center also beats a same-cycle timeout.
        if (press_q[B_CENTER]) begin
          setpoint_d = working_q;
          commit_d   = 1'b1;
          state_d    = S_VIEW;
          timer_d    = '0;
        end else if (press_q[B_UP]) begin
          working_d = (up_sum > {1'b0, MAX_VALUE}) ? MAX_VALUE : up_sum[31:0];
          timer_d   = '0;
        end else if (press_q[B_DOWN]) begin
          working_d = (working_q >= step) ? working_q - step : '0;
          timer_d   = '0;
        end else if (press_q[B_LEFT]) begin
          cursor_d = cursor_q + 3'd1;
          timer_d  = '0;
        end else if (press_q[B_RIGHT]) begin
          cursor_d = cursor_q - 3'd1;
          timer_d  = '0;
        end else if (timer_q == TMO_LAST) begin
          state_d = S_VIEW;
          timer_d = '0;
        end
      end
      default: state_d = S_VIEW;
    endcase
    n_d = (state_d == S_EDIT) ? working_d : live_value;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_VIEW;
      working_q  <= '0;
      cursor_q   <= '0;
      timer_q    <= '0;
      setpoint_q <= INIT_SETPOINT;
      commit_q   <= 1'b0;
      n_q        <= '0;
    end else begin
      state_q    <= state_d;
      working_q  <= working_d;
      cursor_q   <= cursor_d;
      timer_q    <= timer_d;
      setpoint_q <= setpoint_d;
      commit_q   <= commit_d;
      n_q        <= n_d;
    end
  end

  assign n         = n_q;
  assign setpoint  = setpoint_q;
  assign commit    = commit_q;
  assign editing   = (state_q == S_EDIT);
  assign blink_ena = editing;
  assign blink     = editing ? cursor_q : '0;

endmodule
